// File: rtl/mdu_iterative_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master issues ops and consumes results; the slave is the unit.
interface mdu_iterative_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_op, in_a, in_b, flush, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, flush, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide,
// UNROLL bits retired per cycle, valid/ready both sides plus flush.
module mdu_iterative #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mdu_iterative_if.slave  bus
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic            is_div;
    logic            a_sgn;
    logic            b_sgn;
    logic            sa;
    logic            sb;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        is_div = bus.in_op[2];
        a_sgn  = (bus.in_op == 3'b001) || (bus.in_op == 3'b010) ||
                 (bus.in_op[2] && !bus.in_op[0]);
        b_sgn  = (bus.in_op == 3'b001) ||
                 (bus.in_op[2] && !bus.in_op[0]);
        sa     = a_sgn && bus.in_a[XLEN-1];
        sb     = b_sgn && bus.in_b[XLEN-1];
        mag_a  = sa ? -bus.in_a : bus.in_a;
        mag_b  = sb ? -bus.in_b : bus.in_b;
        div0   = is_div && (bus.in_b == '0);
        ovf    = is_div && !bus.in_op[0] &&
                 (bus.in_a == MINV) && (bus.in_b == '1);
        fast_res = '0;
        if (div0)
            fast_res = bus.in_op[1] ? bus.in_a : '1;
        else
            fast_res = bus.in_op[1] ? '0 : MINV;
    end

    // acc holds {partial, multiplier} or {remainder, dividend/quotient}
    logic [2*XLEN-1:0] step;
    logic [XLEN:0]     part;

    always_comb begin
        step = acc_q;
        part = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (op_q[2]) begin
                part = step[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
                if (part[XLEN])
                    step = {step[2*XLEN-2:0], 1'b0};
                else
                    step = {part[XLEN-1:0], step[XLEN-2:0], 1'b1};
            end else begin
                part = {1'b0, step[2*XLEN-1:XLEN]} +
                       (step[0] ? {1'b0, opb_q} : '0);
                step = {part, step[XLEN-1:1]};
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        quo     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem     = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_res = '0;
        unique case (1'b1)
            op_q == 3'b000:                     fix_res = prod[XLEN-1:0];
            !op_q[2] && (op_q[1:0] != 2'b00):   fix_res = prod[2*XLEN-1:XLEN];
            op_q[2:1] == 2'b10:                 fix_res = quo;
            op_q[2:1] == 2'b11:                 fix_res = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    op_d   = bus.in_op;
                    opb_d  = mag_b;
                    acc_d  = {{XLEN{1'b0}}, mag_a};
                    cnt_d  = '0;
                    neg_d  = sa ^ sb;
                    rneg_d = sa;
                    if (div0 || ovf) begin
                        res_d   = fast_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N-1))
                    state_d = FIX;
            end
            FIX: begin
                res_d   = fix_res;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a killed op must leave the previous result visible
        if (bus.flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: UNROLL=1,2,4 instances share one
// stimulus stream and are each checked against a plain-arithmetic model.
module tb_mdu_iterative;

    localparam int XLEN = 32;
    localparam int NU   = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b1;
    logic [2:0]      in_op = 3'd0;
    logic [XLEN-1:0] in_a = '0;
    logic [XLEN-1:0] in_b = '0;

    logic [NU-1:0]   rdy;
    logic [NU-1:0]   ov;
    logic [XLEN-1:0] res [NU];

    int cyc = 0;
    int passed = 0;
    int total = 0;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t          sb [NU][$];
    int            rise_cyc [NU];
    logic [NU-1:0] ov_prev = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        mdu_iterative_if #(.XLEN(XLEN)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_op     = in_op;
        assign bus.in_a      = in_a;
        assign bus.in_b      = in_b;
        assign bus.flush     = flush;
        assign bus.out_ready = out_ready;
        assign rdy[g]        = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign res[g]        = bus.out_result;
        mdu_iterative #(.XLEN(XLEN), .UNROLL(1 << g)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] xs_a, xs_b;
        logic [63:0]        xu_a, xu_b, p;
        logic [31:0]        r;
        int                 ia, ib;
        logic               ovf;
        xs_a = {{32{a[31]}}, a};
        xs_b = {{32{b[31]}}, b};
        xu_a = {32'b0, a};
        xu_b = {32'b0, b};
        ia   = a;
        ib   = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = '0;
        r    = '0;
        case (op)
            3'd0: begin p = xu_a * xu_b; r = p[31:0]; end
            3'd1: begin p = xs_a * xs_b; r = p[63:32]; end
            3'd2: begin p = xs_a * $signed(xu_b); r = p[63:32]; end
            3'd3: begin p = xu_a * xu_b; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // called at #1 after a rising edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        int   n;
        bit   fast;
        exp_t e;
        n = 0;
        while (rdy != '1 && n < 200) begin
            tick(1);
            n++;
        end
        if (rdy != '1) chk("idle_timeout", {29'b0, rdy}, 32'h7);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        tick(1);
        in_valid = 1'b0;
        fast = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 &&
                                      b == 32'hFFFF_FFFF));
        if (push) begin
            for (int g = 0; g < NU; g++) begin
                e.res = ref_model(op, a, b);
                e.acc = cyc;
                e.lat = fast ? 1 : (XLEN / (1 << g)) + 2;
                sb[g].push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 300) begin
            tick(1);
            n++;
        end
        for (int g = 0; g < NU; g++)
            chk($sformatf("drain_u%0d", 1 << g), sb[g].size(), 0);
    endtask

    task automatic silent(input string name);
        logic [NU-1:0] seen;
        seen = '0;
        repeat (40) begin
            tick(1);
            seen |= ov;
        end
        chk(name, {29'b0, seen}, 32'h0);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NU; g++) begin
            if (ov[g] && !ov_prev[g]) rise_cyc[g] = cyc;
            if (ov[g] && out_ready && rst_n) begin
                if (sb[g].size() == 0) begin
                    chk($sformatf("unexpected_valid_u%0d", 1 << g), 1, 0);
                end else begin
                    exp_t e;
                    e = sb[g].pop_front();
                    chk($sformatf("result_u%0d", 1 << g), res[g], e.res);
                    chk($sformatf("latency_u%0d", 1 << g),
                        rise_cyc[g] - e.acc + 1, e.lat);
                end
            end
        end
        ov_prev = ov;
    end

    initial begin
        int            n;
        logic [2:0]    op;
        logic [31:0]   a, b;
        logic [31:0]   hold [NU];
        bit            ok;

        tick(3);
        for (int g = 0; g < NU; g++) begin
            chk($sformatf("rst_ready_u%0d", 1 << g), rdy[g], 1);
            chk($sformatf("rst_valid_u%0d", 1 << g), ov[g], 0);
            chk($sformatf("rst_result_u%0d", 1 << g), res[g], 0);
        end
        rst_n = 1'b1;
        tick(1);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1);
        issue(3'd5, 32'hFFFF_FFF9, 32'd2, 1);
        issue(3'd7, 32'hFFFF_FFF9, 32'd2, 1);
        issue(3'd4, 32'd5, 32'd0, 1);
        issue(3'd6, 32'd5, 32'd0, 1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1);

        repeat (60) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            issue(op, a, b, 1);
        end
        drain();

        out_ready = 1'b0;
        issue(3'd0, 32'd12345, 32'd678, 1);
        n = 0;
        while (ov != '1 && n < 100) begin
            tick(1);
            n++;
        end
        chk("bp_all_valid", {29'b0, ov}, 32'h7);
        for (int g = 0; g < NU; g++) hold[g] = res[g];
        repeat (10) begin
            tick(1);
            ok = (ov == '1) && (rdy == '0);
            for (int g = 0; g < NU; g++) ok &= (res[g] == hold[g]);
            chk("bp_hold", {31'b0, ok}, 1);
        end
        out_ready = 1'b1;
        tick(1);
        chk("bp_release", {26'b0, ov, rdy}, 32'h07);
        drain();

        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        tick(5);
        for (int g = 0; g < NU; g++) hold[g] = res[g];
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_idle", {26'b0, ov, rdy}, 32'h07);
        ok = 1'b1;
        for (int g = 0; g < NU; g++) ok &= (res[g] == hold[g]);
        chk("flush_result_hold", {31'b0, ok}, 1);
        silent("flush_silent");

        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = 3'd0;
        in_a     = 32'd3;
        in_b     = 32'd4;
        tick(1);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_blocks_accept", {29'b0, rdy}, 32'h7);
        silent("flush_accept_silent");

        issue(3'd5, 32'hFFFF_0000, 32'd3, 0);
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {26'b0, ov, rdy}, 32'h07);
        for (int g = 0; g < NU; g++)
            chk($sformatf("rst_mid_result_u%0d", 1 << g), res[g], 0);
        tick(2);
        rst_n = 1'b1;
        silent("rst_silent");

        issue(3'd1, 32'h7FFF_FFFF, 32'h8000_0001, 1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
